// File: rtl/operand_fetch_stage_pkg.sv
// Shared field positions, opcodes and defaults for the operand fetch stage.
// Register-address fields sit at fixed RISC-V positions.
package operand_fetch_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned INSTR_W    = 32;

    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_MSB = 6;

    typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_BRANCH = 7'b1100011;

    // Stores and branches carry an rd-shaped field that is not a destination.
    function automatic logic writes_rd(opcode_t opc);
        return (opc != OPC_STORE) && (opc != OPC_BRANCH);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when EX takes a writing
// instruction, cleared by writeback. Queries see a same-cycle clear as free.
module operand_fetch_stage_reg_scoreboard
    import operand_fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_q1_addr,
    input  logic [ADDR_W-1:0] i_q2_addr,
    input  logic [ADDR_W-1:0] i_q3_addr,
    output logic              o_q1_busy,
    output logic              o_q2_busy,
    output logic              o_q3_busy
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_d;

    // Set is applied after clear so it wins on a same-register collision.
    always_comb begin
        w_pending_d = r_pending;
        if (i_clr_en) begin
            w_pending_d[i_clr_addr] = 1'b0;
        end
        if (i_set_en) begin
            w_pending_d[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_d;
        end
    end

    always_comb begin
        o_q1_busy = r_pending[i_q1_addr] && !(i_clr_en && (i_clr_addr == i_q1_addr));
        o_q2_busy = r_pending[i_q2_addr] && !(i_clr_en && (i_clr_addr == i_q2_addr));
        o_q3_busy = r_pending[i_q3_addr] && !(i_clr_en && (i_clr_addr == i_q3_addr));
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: drives RF read ports, bypasses writeback data,
// stalls on RAW/WAW hazards and registers operands into the ID/EX register.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [INSTR_W-1:0] if_pc,
    output logic [ADDR_W-1:0]  reg_port1,
    output logic [ADDR_W-1:0]  reg_port2,
    input  logic [DATA_W-1:0]  reg_out1,
    input  logic [DATA_W-1:0]  reg_out2,
    input  logic               wb_we,
    input  logic [ADDR_W-1:0]  write_reg,
    input  logic [DATA_W-1:0]  data_in,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [INSTR_W-1:0] ex_pc,
    output logic [INSTR_W-1:0] ex_instr,
    output logic [DATA_W-1:0]  ex_op1,
    output logic [DATA_W-1:0]  ex_op2,
    output logic [ADDR_W-1:0]  ex_rd,
    output logic               ex_rd_we
);

    logic [ADDR_W-1:0]  w_rs1;
    logic [ADDR_W-1:0]  w_rs2;
    logic [ADDR_W-1:0]  w_rd;
    opcode_t            w_opc;
    logic [DATA_W-1:0]  w_op1;
    logic [DATA_W-1:0]  w_op2;
    logic               w_sb_busy1;
    logic               w_sb_busy2;
    logic               w_sb_busy3;
    logic               w_ex_claims;
    logic               w_ex_hazard;
    logic               w_hazard;
    logic               w_accept;
    logic               w_sb_set;

    logic               r_ex_valid;
    logic [INSTR_W-1:0] r_ex_pc;
    logic [INSTR_W-1:0] r_ex_instr;
    logic [DATA_W-1:0]  r_ex_op1;
    logic [DATA_W-1:0]  r_ex_op2;
    logic [ADDR_W-1:0]  r_ex_rd;
    logic               r_ex_rd_we;

    assign w_rs1 = if_instr[RS1_LSB +: ADDR_W];
    assign w_rs2 = if_instr[RS2_LSB +: ADDR_W];
    assign w_rd  = if_instr[RD_LSB +: ADDR_W];
    assign w_opc = if_instr[OPC_MSB:OPC_LSB];

    assign reg_port1 = w_rs1;
    assign reg_port2 = w_rs2;

    // The RF write lands on the same edge we capture, so forward it here.
    assign w_op1 = (wb_we && (write_reg == w_rs1)) ? data_in : reg_out1;
    assign w_op2 = (wb_we && (write_reg == w_rs2)) ? data_in : reg_out2;

    // EX consuming a writing instruction marks its destination pending.
    assign w_sb_set = r_ex_valid && ex_ready && r_ex_rd_we;

    operand_fetch_stage_reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_set_en   (w_sb_set),
        .i_set_addr (r_ex_rd),
        .i_clr_en   (wb_we),
        .i_clr_addr (write_reg),
        .i_q1_addr  (w_rs1),
        .i_q2_addr  (w_rs2),
        .i_q3_addr  (w_rd),
        .o_q1_busy  (w_sb_busy1),
        .o_q2_busy  (w_sb_busy2),
        .o_q3_busy  (w_sb_busy3)
    );

    // The instruction still sitting in ID/EX has not reached the scoreboard yet.
    assign w_ex_claims = r_ex_valid && r_ex_rd_we;
    assign w_ex_hazard = w_ex_claims &&
                         ((r_ex_rd == w_rs1) || (r_ex_rd == w_rs2) || (r_ex_rd == w_rd));
    assign w_hazard    = w_sb_busy1 || w_sb_busy2 || w_sb_busy3 || w_ex_hazard;

    assign if_ready = !reset && !flush && !w_hazard && (!r_ex_valid || ex_ready);
    assign w_accept = if_valid && if_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_ex_pc    <= '0;
            r_ex_instr <= '0;
            r_ex_op1   <= '0;
            r_ex_op2   <= '0;
            r_ex_rd    <= '0;
            r_ex_rd_we <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex_pc    <= if_pc;
            r_ex_instr <= if_instr;
            r_ex_op1   <= w_op1;
            r_ex_op2   <= w_op2;
            r_ex_rd    <= w_rd;
            r_ex_rd_we <= writes_rd(w_opc);
        end else if (flush || ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid = r_ex_valid;
    assign ex_pc    = r_ex_pc;
    assign ex_instr = r_ex_instr;
    assign ex_op1   = r_ex_op1;
    assign ex_op2   = r_ex_op2;
    assign ex_rd    = r_ex_rd;
    assign ex_rd_we = r_ex_rd_we;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus a randomized run
// checked against an in-flight-register model of the pipeline.
module tb_operand_fetch_stage;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    logic        clk = 1'b0;
    logic        reset, flush, if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  reg_port1, reg_port2;
    logic [31:0] reg_out1, reg_out2;
    logic        wb_we;
    logic [4:0]  write_reg;
    logic [31:0] data_in;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_instr, ex_op1, ex_op2;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;

    logic [31:0] rf [32];
    assign reg_out1 = rf[reg_port1];
    assign reg_out2 = rf[reg_port2];

    always #5 clk = ~clk;

    operand_fetch_stage #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .reg_port1 (reg_port1),
        .reg_port2 (reg_port2),
        .reg_out1  (reg_out1),
        .reg_out2  (reg_out2),
        .wb_we     (wb_we),
        .write_reg (write_reg),
        .data_in   (data_in),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_pc     (ex_pc),
        .ex_instr  (ex_instr),
        .ex_op1    (ex_op1),
        .ex_op2    (ex_op2),
        .ex_rd     (ex_rd),
        .ex_rd_we  (ex_rd_we)
    );

    // Model: contents of the ID/EX slot, and registers handed to EX awaiting writeback.
    bit          m_valid;
    logic [31:0] m_pc, m_instr, m_op1, m_op2;
    logic [4:0]  m_rd;
    bit          m_rdwe;
    bit          m_pend [32];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = 7'($urandom);
        f3 = 3'($urandom);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    // A register is unavailable if a write to it is still on its way back.
    function automatic bit in_flight(input logic [4:0] r);
        bit awaiting_wb;
        bit in_slot;
        awaiting_wb = m_pend[r] && !(wb_we && write_reg == r);
        in_slot     = m_valid && m_rdwe && m_rd == r;
        return awaiting_wb || in_slot;
    endfunction

    function automatic bit exp_ready();
        bit blocked;
        blocked = in_flight(if_instr[19:15]) || in_flight(if_instr[24:20]) ||
                  in_flight(if_instr[11:7]);
        return !reset && !flush && !blocked && (!m_valid || ex_ready);
    endfunction

    task automatic model_clear();
        m_valid = 0; m_pc = 0; m_instr = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_rdwe = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input bit exr, input bit fl,
                         input bit we, input logic [4:0] wr, input logic [31:0] d);
        if_valid  = v;
        if_instr  = ins;
        if_pc     = $urandom & 32'hFFFF_FFFC;
        ex_ready  = exr;
        flush     = fl;
        wb_we     = we;
        write_reg = wr;
        data_in   = d;
    endtask

    // Advance one clock, then update the model from the inputs that were applied.
    task automatic cycle();
        bit acc;
        bit cons;
        logic [4:0] rs1, rs2;
        @(posedge clk);
        #1;
        if (reset) begin
            model_clear();
        end else begin
            acc  = if_valid && exp_ready();
            cons = m_valid && ex_ready;
            rs1  = if_instr[19:15];
            rs2  = if_instr[24:20];
            if (wb_we) m_pend[write_reg] = 0;
            if (cons && m_rdwe) m_pend[m_rd] = 1;
            if (acc) begin
                m_valid = 1;
                m_pc    = if_pc;
                m_instr = if_instr;
                m_op1   = (wb_we && write_reg == rs1) ? data_in : rf[rs1];
                m_op2   = (wb_we && write_reg == rs2) ? data_in : rf[rs2];
                m_rd    = if_instr[11:7];
                m_rdwe  = !(if_instr[6:0] == OP_STORE || if_instr[6:0] == OP_BRANCH);
            end else if (flush || ex_ready) begin
                m_valid = 0;
            end
        end
        if (wb_we) rf[write_reg] = data_in;
    endtask

    // Empty the slot and write back every register so nothing is outstanding.
    task automatic drain();
        drive(0, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        cycle();
        for (int r = 0; r < 32; r++) begin
            drive(0, 32'h0, 1, 0, 1, 5'(r), rf[r]);
            cycle();
        end
        drive(0, 32'h0, 1, 0, 0, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        n_vec++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid);
        end
        n_vec++;
        if ({ex_pc, ex_instr, ex_op1, ex_op2} !== 128'h0) begin
            n_err++; $display("FAIL reset_ex_fields: got %h %h %h %h want 0", ex_pc, ex_instr,
                              ex_op1, ex_op2);
        end
        n_vec++;
        if ({ex_rd, ex_rd_we} !== 6'h0) begin
            n_err++; $display("FAIL reset_rd: got rd=%0d we=%b want 0/0", ex_rd, ex_rd_we);
        end
        n_vec++;
        if (if_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_if_ready: got %b want 0", if_ready);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] ins;
        drain();
        drive(0, 32'h0, 1, 0, 1, 5'd1, 32'hAA);
        cycle();
        ins = mk(OP_ALU, 5'd2, 5'd1, 5'd4);
        drive(1, ins, 1, 0, 1, 5'd1, 32'h55);
        #1;
        n_vec++;
        if (if_ready !== 1'b1) begin
            n_err++; $display("FAIL bypass_ready: got %b want 1", if_ready);
        end
        n_vec++;
        if (reg_port1 !== 5'd1 || reg_port2 !== 5'd4) begin
            n_err++; $display("FAIL bypass_ports: got %0d/%0d want 1/4", reg_port1, reg_port2);
        end
        cycle();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_op1 !== 32'h55) begin
            n_err++; $display("FAIL bypass_op1: got v=%b op1=%h want v=1 op1=00000055",
                              ex_valid, ex_op1);
        end
        n_vec++;
        if (ex_op2 !== rf[4] || ex_rd !== 5'd2 || ex_instr !== ins) begin
            n_err++; $display("FAIL bypass_fields: got op2=%h rd=%0d ins=%h want %h 2 %h",
                              ex_op2, ex_rd, ex_instr, rf[4], ins);
        end
    endtask

    task automatic test_raw_stall();
        logic [31:0] a, b;
        drain();
        a = mk(OP_ALU, 5'd3, 5'd6, 5'd7);
        drive(1, a, 1, 0, 0, 5'd0, 32'h0);
        cycle();
        b = mk(OP_ALU, 5'd8, 5'd9, 5'd3);
        for (int k = 0; k < 2; k++) begin
            drive(1, b, 1, 0, 0, 5'd0, 32'h0);
            #1;
            n_vec++;
            if (if_ready !== 1'b0) begin
                n_err++; $display("FAIL raw_stall_ready[%0d]: got %b want 0", k, if_ready);
            end
            cycle();
        end
        n_vec++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL raw_bubble: got ex_valid=%b want 0", ex_valid);
        end
        drive(1, b, 1, 0, 1, 5'd3, 32'h1234);
        #1;
        n_vec++;
        if (if_ready !== 1'b1) begin
            n_err++; $display("FAIL raw_release: got %b want 1", if_ready);
        end
        cycle();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_op2 !== 32'h1234 || ex_instr !== b) begin
            n_err++; $display("FAIL raw_op2: got v=%b op2=%h want v=1 op2=00001234",
                              ex_valid, ex_op2);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, pc_a, pc_b, op1_a;
        drain();
        a = mk(OP_ALU, 5'd10, 5'd12, 5'd13);
        drive(1, a, 0, 0, 0, 5'd0, 32'h0);
        pc_a  = if_pc;
        op1_a = rf[12];
        cycle();
        b = mk(OP_ALU, 5'd11, 5'd14, 5'd15);
        for (int k = 0; k < 3; k++) begin
            drive(1, b, 0, 0, 0, 5'd0, 32'h0);
            #1;
            n_vec++;
            if (if_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", k, if_ready);
            end
            cycle();
            n_vec++;
            if (ex_valid !== 1'b1 || ex_instr !== a || ex_pc !== pc_a || ex_op1 !== op1_a) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b ins=%h pc=%h op1=%h want 1 %h %h %h",
                                  k, ex_valid, ex_instr, ex_pc, ex_op1, a, pc_a, op1_a);
            end
        end
        drive(1, b, 1, 0, 0, 5'd0, 32'h0);
        pc_b = if_pc;
        #1;
        n_vec++;
        if (if_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release: got %b want 1", if_ready);
        end
        cycle();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_instr !== b || ex_pc !== pc_b) begin
            n_err++; $display("FAIL bp_next: got v=%b ins=%h pc=%h want 1 %h %h",
                              ex_valid, ex_instr, ex_pc, b, pc_b);
        end
    endtask

    task automatic test_flush();
        logic [31:0] a, c, d;
        drain();
        a = mk(OP_ALU, 5'd9, 5'd16, 5'd17);
        drive(1, a, 0, 0, 0, 5'd0, 32'h0);
        cycle();
        c = mk(OP_ALU, 5'd18, 5'd19, 5'd20);
        drive(1, c, 0, 1, 0, 5'd0, 32'h0);
        #1;
        n_vec++;
        if (if_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_ready: got %b want 0", if_ready);
        end
        cycle();
        n_vec++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_valid: got %b want 0", ex_valid);
        end
        d = mk(OP_ALU, 5'd21, 5'd9, 5'd22);
        drive(1, d, 1, 0, 0, 5'd0, 32'h0);
        #1;
        n_vec++;
        if (if_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_no_pending: got %b want 1", if_ready);
        end
        cycle();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_instr !== d) begin
            n_err++; $display("FAIL flush_next: got v=%b ins=%h want 1 %h", ex_valid, ex_instr, d);
        end
    endtask

    task automatic test_store();
        logic [31:0] s, e;
        drain();
        s = mk(OP_STORE, 5'd5, 5'd23, 5'd24);
        drive(1, s, 1, 0, 0, 5'd0, 32'h0);
        cycle();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_rd_we !== 1'b0 || ex_rd !== 5'd5) begin
            n_err++; $display("FAIL store_rd_we: got v=%b we=%b rd=%0d want 1 0 5",
                              ex_valid, ex_rd_we, ex_rd);
        end
        e = mk(OP_ALU, 5'd25, 5'd5, 5'd26);
        for (int k = 0; k < 2; k++) begin
            drive(1, e, 1, 0, 0, 5'd0, 32'h0);
            #1;
            n_vec++;
            if (if_ready !== 1'b1) begin
                n_err++; $display("FAIL store_no_stall[%0d]: got %b want 1", k, if_ready);
            end
            cycle();
            e = mk(OP_ALU, 5'd27, 5'd5, 5'd28);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] f;
        drain();
        drive(1, mk(OP_ALU, 5'd7, 5'd1, 5'd2), 1, 0, 0, 5'd0, 32'h0);
        cycle();
        drive(1, mk(OP_ALU, 5'd8, 5'd3, 5'd4), 1, 0, 0, 5'd0, 32'h0);
        cycle();
        n_vec++;
        if (ex_valid !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre: got ex_valid=%b want 1", ex_valid);
        end
        drive(1, mk(OP_ALU, 5'd10, 5'd11, 5'd12), 0, 0, 0, 5'd0, 32'h0);
        reset = 1;
        #1;
        model_clear();
        test_reset();
        cycle();
        reset = 0;
        f = mk(OP_ALU, 5'd13, 5'd7, 5'd8);
        drive(1, f, 1, 0, 0, 5'd0, 32'h0);
        #1;
        n_vec++;
        if (if_ready !== 1'b1) begin
            n_err++; $display("FAIL midrst_sb_clear: got %b want 1", if_ready);
        end
        cycle();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_instr !== f) begin
            n_err++; $display("FAIL midrst_accept: got v=%b ins=%h want 1 %h", ex_valid, ex_instr, f);
        end
    endtask

    task automatic test_random();
        bit          v, exr, fl, we, exp;
        logic [6:0]  opc;
        logic [31:0] ins;
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0: opc = OP_ALU;
                1: opc = OP_STORE;
                2: opc = OP_BRANCH;
                default: opc = OP_LOAD;
            endcase
            ins = mk(opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)));
            v   = $urandom_range(0, 3) != 0;
            exr = $urandom_range(0, 3) != 0;
            fl  = $urandom_range(0, 15) == 0;
            we  = $urandom_range(0, 1) == 0;
            drive(v, ins, exr, fl, we, 5'($urandom_range(0, 7)), $urandom);
            #1;
            exp = exp_ready();
            n_vec++;
            if (if_ready !== exp) begin
                n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, if_ready, exp);
            end
            n_vec++;
            if (reg_port1 !== ins[19:15] || reg_port2 !== ins[24:20]) begin
                n_err++; $display("FAIL rnd_ports c%0d: got %0d/%0d want %0d/%0d", c, reg_port1,
                                  reg_port2, ins[19:15], ins[24:20]);
            end
            cycle();
            n_vec++;
            if (ex_valid !== m_valid) begin
                n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", c, ex_valid, m_valid);
            end else if (m_valid) begin
                n_vec++;
                if ({ex_pc, ex_instr, ex_op1, ex_op2, ex_rd, ex_rd_we} !==
                    {m_pc, m_instr, m_op1, m_op2, m_rd, m_rdwe}) begin
                    n_err++;
                    $display("FAIL rnd_fields c%0d: got %h %h %h %h %0d %b want %h %h %h %h %0d %b",
                             c, ex_pc, ex_instr, ex_op1, ex_op2, ex_rd, ex_rd_we,
                             m_pc, m_instr, m_op1, m_op2, m_rd, m_rdwe);
                end
            end
        end
    endtask

    initial begin
        reset = 1;
        drive(0, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 0;
        test_bypass();
        test_raw_stall();
        test_backpressure();
        test_flush();
        test_store();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
